// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: sequences each instruction through shared-memory
// fetch, decode, execute, memory and writeback states, with memory timeout and retire count.
module multicycle_control #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned RETIRE_W    = 32,
  parameter int unsigned TRAP_STICKY = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic                mem_ready,
  input  logic                branch_taken,
  output logic                mem_req,
  output logic                mem_we,
  output logic                adr_src,
  output logic                ir_write,
  output logic                pc_write,
  output logic                reg_write,
  output logic [1:0]          alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic [1:0]          result_src,
  output logic [2:0]          imm_src,
  output logic [3:0]          state_o,
  output logic                illegal,
  output logic [RETIRE_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC_R = 4'd6,  S_EXEC_I = 4'd7,
    S_ALUWB  = 4'd8,  S_BRANCH = 4'd9,  S_JAL    = 4'd10, S_JALR   = 4'd11,
    S_LUI    = 4'd12, S_AUIPC  = 4'd13, S_TRAP   = 4'd15
  } state_t;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam int unsigned     WAIT_W     = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
  localparam bit              TIMEOUT_EN = (MEM_TIMEOUT != 0);

  state_t              r_state, w_state_n;
  logic [WAIT_W-1:0]   r_wait;
  logic [RETIRE_W-1:0] r_retired;
  logic                w_waiting, w_retire, w_timeout;

  assign w_timeout = TIMEOUT_EN && (r_wait == WAIT_LIMIT);
  assign state_o   = r_state;
  assign retired   = r_retired;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_wait    <= '0;
      r_retired <= '0;
    end else begin
      r_state <= w_state_n;
      if (w_state_n != r_state) r_wait <= '0;
      else if (w_waiting)       r_wait <= r_wait + WAIT_W'(1);
      if (w_retire) r_retired <= r_retired + RETIRE_W'(1);
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_waiting  = 1'b0;
    w_retire   = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    result_src = 2'b00;
    imm_src    = 3'b000;
    illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b10;
        w_waiting = !mem_ready;
        if (mem_ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          w_state_n = S_DECODE;
        end else if (w_timeout) w_state_n = S_TRAP;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = IMM_B;
        case (opcode)
          7'b0000011, 7'b0100011: w_state_n = S_MEMADR;
          7'b0110011:             w_state_n = S_EXEC_R;
          7'b0010011:             w_state_n = S_EXEC_I;
          7'b1100011:             w_state_n = S_BRANCH;
          7'b1101111:             w_state_n = S_JAL;
          7'b1100111:             w_state_n = (funct3 == 3'b000) ? S_JALR : S_TRAP;
          7'b0110111:             w_state_n = S_LUI;
          7'b0010111:             w_state_n = S_AUIPC;
          default:                w_state_n = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        // Only loads and stores reach here; opcode bit 5 separates them.
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = opcode[5] ? IMM_S : IMM_I;
        w_state_n = opcode[5] ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req   = 1'b1;
        adr_src   = 1'b1;
        w_waiting = !mem_ready;
        if (mem_ready)      w_state_n = S_MEMWB;
        else if (w_timeout) w_state_n = S_TRAP;
      end
      S_MEMWR: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        adr_src   = 1'b1;
        w_waiting = !mem_ready;
        if (mem_ready) begin
          w_retire  = 1'b1;
          w_state_n = S_FETCH;
        end else if (w_timeout) w_state_n = S_TRAP;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        result_src = 2'b01;
        w_retire   = 1'b1;
        w_state_n  = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        w_state_n = S_ALUWB;
      end
      S_EXEC_I: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        imm_src   = IMM_I;
        w_state_n = S_ALUWB;
      end
      S_LUI: begin
        alu_src_b = 2'b01;
        alu_op    = 2'b11;
        imm_src   = IMM_U;
        w_state_n = S_ALUWB;
      end
      S_AUIPC: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = IMM_U;
        w_state_n = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        w_retire  = 1'b1;
        w_state_n = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        pc_write  = branch_taken;
        w_retire  = 1'b1;
        w_state_n = S_FETCH;
      end
      S_JAL, S_JALR: begin
        // rd takes oldPC+4 straight from the ALU; the PC loads the target held in ALUOut.
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        imm_src    = (r_state == S_JAL) ? IMM_J : IMM_I;
        reg_write  = 1'b1;
        pc_write   = 1'b1;
        result_src = 2'b10;
        w_retire   = 1'b1;
        w_state_n  = S_FETCH;
      end
      S_TRAP: begin
        illegal   = 1'b1;
        w_state_n = (TRAP_STICKY != 0) ? S_TRAP : S_FETCH;
      end
      default: w_state_n = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed vector table and corner sequences, then random
// stimulus, on a default instance and a short-timeout / 3-bit-counter / non-sticky instance.
module tb_multicycle_control;

  typedef struct packed {
    logic mem_req, mem_we, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] a, b, aop, rs;
    logic [2:0] imm;
    logic ill;
  } ctl_t;

  typedef struct packed {
    logic [6:0] op;
    logic [2:0] f3;
    logic bt;
    logic [2:0] len;
    logic [4:0][3:0] st;
    logic [4:0] rw, pw, mw;
  } vec_t;

  logic clk = 1'b0, rst = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic mem_ready = 1'b0, branch_taken = 1'b0;

  logic mem_req0, mem_we0, adr_src0, ir_write0, pc_write0, reg_write0, illegal0;
  logic [1:0] alu_src_a0, alu_src_b0, alu_op0, result_src0;
  logic [2:0] imm_src0;
  logic [3:0] state0;
  logic [31:0] retired0;
  logic mem_req1, mem_we1, adr_src1, ir_write1, pc_write1, reg_write1, illegal1;
  logic [1:0] alu_src_a1, alu_src_b1, alu_op1, result_src1;
  logic [2:0] imm_src1;
  logic [3:0] state1;
  logic [2:0] retired1;

  ctl_t g0, g1;
  assign g0 = {mem_req0, mem_we0, adr_src0, ir_write0, pc_write0, reg_write0,
               alu_src_a0, alu_src_b0, alu_op0, result_src0, imm_src0, illegal0};
  assign g1 = {mem_req1, mem_we1, adr_src1, ir_write1, pc_write1, reg_write1,
               alu_src_a1, alu_src_b1, alu_op1, result_src1, imm_src1, illegal1};

  multicycle_control #(.MEM_TIMEOUT(15), .RETIRE_W(32), .TRAP_STICKY(1)) dut0 (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .mem_req(mem_req0), .mem_we(mem_we0), .adr_src(adr_src0),
    .ir_write(ir_write0), .pc_write(pc_write0), .reg_write(reg_write0),
    .alu_src_a(alu_src_a0), .alu_src_b(alu_src_b0), .alu_op(alu_op0),
    .result_src(result_src0), .imm_src(imm_src0), .state_o(state0), .illegal(illegal0),
    .retired(retired0));

  multicycle_control #(.MEM_TIMEOUT(4), .RETIRE_W(3), .TRAP_STICKY(0)) dut1 (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .mem_req(mem_req1), .mem_we(mem_we1), .adr_src(adr_src1),
    .ir_write(ir_write1), .pc_write(pc_write1), .reg_write(reg_write1),
    .alu_src_a(alu_src_a1), .alu_src_b(alu_src_b1), .alu_op(alu_op1),
    .result_src(result_src1), .imm_src(imm_src1), .state_o(state1), .illegal(illegal1),
    .retired(retired1));

  always #5 clk = ~clk;

  int cmp_n = 0, fail_n = 0;
  logic [6:0] cur_op = 7'b0110011;
  logic [2:0] cur_f3 = 3'b000;

  // Reference model: per-instruction plan of post-decode phases, popped as each phase ends.
  int m_st[2], m_wait[2], m_pidx[2], m_plen[2];
  int m_plan[2][3];
  int unsigned m_ret[2];
  int lim[2];
  bit sticky[2];
  int unsigned rmask[2];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    cmp_n++;
    if (got !== exp) begin
      fail_n++;
      $display("FAIL %s: got %0h, required %0h", nm, got, exp);
    end
  endtask

  function automatic ctl_t exp_ctl(int st, logic [6:0] op, logic rdy, logic bt);
    ctl_t c;
    c = '0;
    case (st)
      0:  begin c.mem_req = 1; c.b = 2'b10; c.ir_write = rdy; c.pc_write = rdy; end
      1:  begin c.a = 2'b01; c.b = 2'b01; c.imm = 3'b010; end
      2:  begin c.a = 2'b10; c.b = 2'b01; c.imm = (op == 7'b0100011) ? 3'b001 : 3'b000; end
      3:  begin c.mem_req = 1; c.adr_src = 1; end
      4:  begin c.reg_write = 1; c.rs = 2'b01; end
      5:  begin c.mem_req = 1; c.mem_we = 1; c.adr_src = 1; end
      6:  begin c.a = 2'b10; c.aop = 2'b10; end
      7:  begin c.a = 2'b10; c.b = 2'b01; c.aop = 2'b10; c.imm = 3'b000; end
      8:  begin c.reg_write = 1; end
      9:  begin c.a = 2'b10; c.aop = 2'b01; c.pc_write = bt; end
      10: begin c.a = 2'b01; c.b = 2'b10; c.imm = 3'b011; c.reg_write = 1; c.pc_write = 1; c.rs = 2'b10; end
      11: begin c.a = 2'b01; c.b = 2'b10; c.imm = 3'b000; c.reg_write = 1; c.pc_write = 1; c.rs = 2'b10; end
      12: begin c.b = 2'b01; c.aop = 2'b11; c.imm = 3'b100; end
      13: begin c.a = 2'b01; c.b = 2'b01; c.imm = 3'b100; end
      15: c.ill = 1;
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic void set_plan(int k, int n, int p0, int p1, int p2);
    m_plen[k] = n; m_pidx[k] = 0;
    m_plan[k][0] = p0; m_plan[k][1] = p1; m_plan[k][2] = p2;
  endfunction

  function automatic void step_model(int k, logic rdy, logic [6:0] op, logic [2:0] f3);
    int cur, nxt;
    bit adv;
    cur = m_st[k]; nxt = cur; adv = 0;
    if (cur == 0 || cur == 3 || cur == 5) begin
      if (rdy) adv = 1;
      else if (lim[k] != 0 && m_wait[k] == lim[k]) nxt = 15;
      else m_wait[k]++;
    end else adv = (cur != 15);
    if (cur == 1) begin
      adv = 0;
      case (op)
        7'b0000011: set_plan(k, 3, 2, 3, 4);
        7'b0100011: set_plan(k, 2, 2, 5, 0);
        7'b0110011: set_plan(k, 2, 6, 8, 0);
        7'b0010011: set_plan(k, 2, 7, 8, 0);
        7'b1100011: set_plan(k, 1, 9, 0, 0);
        7'b1101111: set_plan(k, 1, 10, 0, 0);
        7'b1100111: set_plan(k, 1, (f3 == 3'b000) ? 11 : 15, 0, 0);
        7'b0110111: set_plan(k, 2, 12, 8, 0);
        7'b0010111: set_plan(k, 2, 13, 8, 0);
        default:    set_plan(k, 1, 15, 0, 0);
      endcase
      nxt = m_plan[k][0];
      m_pidx[k] = 1;
    end else if (cur == 15) nxt = sticky[k] ? 15 : 0;
    if (adv) begin
      if (cur == 0) nxt = 1;
      else if (m_pidx[k] < m_plen[k]) begin
        nxt = m_plan[k][m_pidx[k]];
        m_pidx[k] = m_pidx[k] + 1;
      end else begin
        nxt = 0;
        m_ret[k] = (m_ret[k] + 1) & rmask[k];
      end
    end
    if (nxt != cur) m_wait[k] = 0;
    m_st[k] = nxt;
  endfunction

  task automatic check_all();
    chk("state0", 64'(state0), 64'(m_st[0]));
    chk("ctl0", 64'(g0), 64'(exp_ctl(m_st[0], opcode, mem_ready, branch_taken)));
    chk("retired0", 64'(retired0), 64'(m_ret[0]));
    chk("state1", 64'(state1), 64'(m_st[1]));
    chk("ctl1", 64'(g1), 64'(exp_ctl(m_st[1], opcode, mem_ready, branch_taken)));
    chk("retired1", 64'(retired1), 64'(m_ret[1]));
  endtask

  task automatic drive(input logic rdy, input logic b);
    @(negedge clk);
    mem_ready = rdy; branch_taken = b; opcode = cur_op; funct3 = cur_f3;
    #1 check_all();
  endtask

  task automatic clk_edge();
    @(posedge clk);
    step_model(0, mem_ready, opcode, funct3);
    step_model(1, mem_ready, opcode, funct3);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_wait[k] = 0; m_ret[k] = 0; m_plen[k] = 0; m_pidx[k] = 0;
    end
    chk("rst_state0", 64'(state0), 64'd0);
    chk("rst_retired0", 64'(retired0), 64'd0);
    chk("rst_adr_src0", 64'(adr_src0), 64'd0);
    chk("rst_state1", 64'(state1), 64'd0);
    check_all();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic vec_t mk(logic [6:0] op, logic [2:0] f3, logic bt, int len,
                              int s0, int s1, int s2, int s3, int s4,
                              logic [4:0] rw, logic [4:0] pw, logic [4:0] mw);
    vec_t v;
    v.op = op; v.f3 = f3; v.bt = bt; v.len = 3'(len);
    v.st[0] = 4'(s0); v.st[1] = 4'(s1); v.st[2] = 4'(s2); v.st[3] = 4'(s3); v.st[4] = 4'(s4);
    v.rw = rw; v.pw = pw; v.mw = mw;
    return v;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[10];
    logic [6:0] ops[9];
    int unsigned exp_ret;

    lim[0] = 15; sticky[0] = 1; rmask[0] = 32'hFFFF_FFFF;
    lim[1] = 4;  sticky[1] = 0; rmask[1] = 32'h7;
    ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011;
    ops[3] = 7'b0010011; ops[4] = 7'b1100011; ops[5] = 7'b1101111;
    ops[6] = 7'b1100111; ops[7] = 7'b0110111; ops[8] = 7'b0010111;

    // mask bit c corresponds to cycle c of the instruction, cycle 0 being FETCH
    tbl[0] = mk(7'b0110011, 3'd0, 1'b0, 4, 0, 1, 6, 8, 0, 5'b01000, 5'b00001, 5'b00000);
    tbl[1] = mk(7'b0010011, 3'd0, 1'b0, 4, 0, 1, 7, 8, 0, 5'b01000, 5'b00001, 5'b00000);
    tbl[2] = mk(7'b0000011, 3'd2, 1'b0, 5, 0, 1, 2, 3, 4, 5'b10000, 5'b00001, 5'b00000);
    tbl[3] = mk(7'b0100011, 3'd2, 1'b0, 4, 0, 1, 2, 5, 0, 5'b00000, 5'b00001, 5'b01000);
    tbl[4] = mk(7'b1100011, 3'd0, 1'b0, 3, 0, 1, 9, 0, 0, 5'b00000, 5'b00001, 5'b00000);
    tbl[5] = mk(7'b1100011, 3'd0, 1'b1, 3, 0, 1, 9, 0, 0, 5'b00000, 5'b00101, 5'b00000);
    tbl[6] = mk(7'b1101111, 3'd0, 1'b0, 3, 0, 1, 10, 0, 0, 5'b00100, 5'b00101, 5'b00000);
    tbl[7] = mk(7'b1100111, 3'd0, 1'b0, 3, 0, 1, 11, 0, 0, 5'b00100, 5'b00101, 5'b00000);
    tbl[8] = mk(7'b0110111, 3'd0, 1'b0, 4, 0, 1, 12, 8, 0, 5'b01000, 5'b00001, 5'b00000);
    tbl[9] = mk(7'b0010111, 3'd0, 1'b0, 4, 0, 1, 13, 8, 0, 5'b01000, 5'b00001, 5'b00000);

    do_reset();
    exp_ret = 0;
    for (int i = 0; i < 10; i++) begin
      cur_op = tbl[i].op; cur_f3 = tbl[i].f3;
      for (int c = 0; c < int'(tbl[i].len); c++) begin
        drive(1'b1, tbl[i].bt);
        chk("tbl_state", 64'(state0), 64'(tbl[i].st[c]));
        chk("tbl_reg_write", 64'(reg_write0), 64'(tbl[i].rw[c]));
        chk("tbl_pc_write", 64'(pc_write0), 64'(tbl[i].pw[c]));
        chk("tbl_mem_we", 64'(mem_we0), 64'(tbl[i].mw[c]));
        clk_edge();
      end
      #1 exp_ret++;
      chk("tbl_retired", 64'(retired0), 64'(exp_ret));
    end

    // load with three stall cycles in MEMRD
    cur_op = 7'b0000011; cur_f3 = 3'd2;
    for (int c = 0; c < 3; c++) begin drive(1'b1, 1'b0); clk_edge(); end
    for (int c = 0; c < 4; c++) begin
      drive(c == 3, 1'b0);
      chk("lw_state", 64'(state0), 64'd3);
      chk("lw_req_adr", 64'({mem_req0, adr_src0}), 64'b11);
      clk_edge();
    end
    drive(1'b1, 1'b0);
    chk("lw_wb", 64'({state0, reg_write0, result_src0}), 64'({4'd4, 1'b1, 2'b01}));
    clk_edge();
    #1 chk("lw_retired", 64'(retired0), 64'(exp_ret + 1));

    // illegal opcode and bad JALR funct3 park the sticky instance in TRAP
    for (int t = 0; t < 2; t++) begin
      do_reset();
      cur_op = (t == 0) ? 7'b1111111 : 7'b1100111;
      cur_f3 = (t == 0) ? 3'd0 : 3'd1;
      for (int c = 0; c < 2; c++) begin drive(1'b1, 1'b0); clk_edge(); end
      for (int c = 0; c < 20; c++) begin
        drive(1'b1, 1'b0);
        chk("trap_state", 64'(state0), 64'd15);
        chk("trap_illegal", 64'(illegal0), 64'd1);
        clk_edge();
      end
      #1 chk("trap_retired", 64'(retired0), 64'd0);
    end

    // FETCH timeout on the 4-cycle instance; the non-sticky trap returns to FETCH
    do_reset();
    cur_op = 7'b0110011; cur_f3 = 3'd0;
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, 1'b0);
      chk("to_wait_state1", 64'(state1), 64'd0);
      clk_edge();
    end
    drive(1'b0, 1'b0);
    chk("to_trap1", 64'({state1, illegal1}), 64'({4'd15, 1'b1}));
    clk_edge();
    drive(1'b0, 1'b0);
    chk("to_recover1", 64'(state1), 64'd0);
    clk_edge();

    // ready arriving on the limit cycle completes normally
    do_reset();
    for (int c = 0; c < 4; c++) begin drive(1'b0, 1'b0); clk_edge(); end
    drive(1'b1, 1'b0); clk_edge();
    drive(1'b1, 1'b0);
    chk("to_limit_ok1", 64'(state1), 64'd1);
    clk_edge();

    // default instance times out after 15 wait cycles
    do_reset();
    for (int c = 0; c < 16; c++) begin drive(1'b0, 1'b0); clk_edge(); end
    drive(1'b0, 1'b0);
    chk("to_trap0", 64'(state0), 64'd15);
    clk_edge();

    // nine ALU instructions wrap the 3-bit counter
    do_reset();
    cur_op = 7'b0010011; cur_f3 = 3'd0;
    for (int n = 0; n < 9; n++)
      for (int c = 0; c < 4; c++) begin drive(1'b1, 1'b0); clk_edge(); end
    #1;
    chk("wrap_retired1", 64'(retired1), 64'd1);
    chk("wrap_retired0", 64'(retired0), 64'd9);

    // reset asserted while a load waits in MEMRD
    cur_op = 7'b0000011; cur_f3 = 3'd2;
    for (int c = 0; c < 3; c++) begin drive(1'b1, 1'b0); clk_edge(); end
    drive(1'b0, 1'b0); clk_edge();
    #1 chk("midrd_state0", 64'(state0), 64'd3);
    do_reset();

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 199) do_reset();
      else begin
        if (m_st[0] != 1 && m_st[0] != 2 && m_st[1] != 1 && m_st[1] != 2 &&
            $urandom_range(0, 3) == 0) begin
          int r;
          r = int'($urandom_range(0, 15));
          if (r < 9) begin
            cur_op = ops[r];
            cur_f3 = (r == 6 && $urandom_range(0, 1) == 1) ? 3'($urandom_range(0, 7)) : 3'd0;
          end else if (r < 14) begin
            cur_op = ops[$urandom_range(2, 4)];
            cur_f3 = 3'($urandom_range(0, 7));
          end else begin
            cur_op = 7'($urandom_range(0, 127));
            cur_f3 = 3'($urandom_range(0, 7));
          end
        end
        drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
        clk_edge();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
    $finish;
  end

endmodule
